// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data-memory target for the MEM-stage
// MemRead/MemWrite interface. A request is accepted in IDLE, held for
// LATENCY stall cycles in total, and answered with a one-cycle Resp_Valid.
// Optional build macro: DMEM_PERF_CNT_EN adds saturating read, write and
// stall-cycle counters.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_Data,
    output logic [31:0] Read_data,
    output logic        Mem_Stall,
    output logic        Resp_Valid,
    output logic        Addr_Err
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0] Rd_Count,
    output logic [31:0] Wr_Count,
    output logic [31:0] Stall_Count
`endif
);

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
    localparam bit         LAT_ONE  = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [3:0]              cnt_r;
    logic [3:0]              cnt_nxt_s;
    logic                    req_s;
    logic                    req_err_s;
    logic                    load_s;
    logic                    access_s;

    // Request captured at acceptance; the pipeline should hold it, but the
    // latched copy is what completes even if the inputs drop early.
    logic [ADDR_WIDTH-1:0]   idx_r;
    logic [31:0]             wdata_r;
    logic                    is_rd_r;
    logic                    is_wr_r;
    logic                    err_r;

    // Access-side view: live inputs when the access happens on the
    // acceptance edge itself (LATENCY=1), latched request otherwise.
    logic [ADDR_WIDTH-1:0]   acc_idx_s;
    logic [31:0]             acc_wdata_s;
    logic                    acc_rd_s;
    logic                    acc_wr_s;
    logic                    acc_err_s;

    logic [31:0]             mem_r [DEPTH];

    // Upper address bits select nothing: the word index wraps.
    logic                    addr_unused_s;
    assign addr_unused_s = ^Address[31:ADDR_WIDTH+2];

    assign req_s     = MemRead | MemWrite;
    assign req_err_s = (Address[1:0] != 2'b00) | (MemRead & MemWrite);

    // Select which copy of the request the memory access uses.
    always_comb begin
        acc_idx_s   = idx_r;
        acc_wdata_s = wdata_r;
        acc_rd_s    = is_rd_r;
        acc_wr_s    = is_wr_r;
        acc_err_s   = err_r;
        if (state_r == IDLE) begin
            acc_idx_s   = Address[ADDR_WIDTH+1:2];
            acc_wdata_s = Write_Data;
            acc_rd_s    = MemRead;
            acc_wr_s    = MemWrite;
            acc_err_s   = req_err_s;
        end else begin
            acc_idx_s   = idx_r;
        end
    end

    // Next-state, counter and stall decode for the IDLE/BUSY/RESP sequencer.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        load_s      = 1'b0;
        access_s    = 1'b0;
        Mem_Stall   = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    Mem_Stall = 1'b1;
                    load_s    = 1'b1;
                    if (LAT_ONE) begin
                        state_nxt_s = RESP;
                        access_s    = 1'b1;
                    end else begin
                        state_nxt_s = BUSY;
                        cnt_nxt_s   = CNT_LOAD;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                Mem_Stall = 1'b1;
                cnt_nxt_s = cnt_r - 4'd1;
                // The count reaching zero on this edge completes the access.
                if (cnt_r == 4'd1) begin
                    state_nxt_s = RESP;
                    access_s    = 1'b1;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Sequencer state and latency counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Capture the request on the acceptance edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            idx_r   <= '0;
            wdata_r <= 32'd0;
            is_rd_r <= 1'b0;
            is_wr_r <= 1'b0;
            err_r   <= 1'b0;
        end else if (load_s) begin
            idx_r   <= Address[ADDR_WIDTH+1:2];
            wdata_r <= Write_Data;
            is_rd_r <= MemRead;
            is_wr_r <= MemWrite;
            err_r   <= req_err_s;
        end
    end

    // Memory array and registered response; reset discards any pending write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
            Read_data  <= 32'd0;
            Resp_Valid <= 1'b0;
            Addr_Err   <= 1'b0;
        end else begin
            Resp_Valid <= access_s;
            Addr_Err   <= access_s & acc_err_s;
            if (access_s && !acc_err_s && acc_wr_s) begin
                mem_r[acc_idx_s] <= acc_wdata_s;
            end
            if (access_s && !acc_err_s && acc_rd_s) begin
                Read_data <= mem_r[acc_idx_s];
            end
        end
    end

`ifdef DMEM_PERF_CNT_EN
    // Saturating increment shared by the three performance counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Count successful completions in RESP and every stalled cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            Rd_Count    <= 32'd0;
            Wr_Count    <= 32'd0;
            Stall_Count <= 32'd0;
        end else begin
            if (state_r == RESP && is_rd_r && !err_r) begin
                Rd_Count <= sat_inc(Rd_Count);
            end
            if (state_r == RESP && is_wr_r && !err_r) begin
                Wr_Count <= sat_inc(Wr_Count);
            end
            if (Mem_Stall) begin
                Stall_Count <= sat_inc(Stall_Count);
            end
        end
    end
`endif

endmodule
